// File: rtl/tio_sync_ctrl.sv
// ----------------------------------------------------------------------------
// tio_sync_ctrl
//
// Sync controller for the sysclk domain. When the TURF sends a sync request,
// the block waits sync_offset sysclks. It then pulses sync_o, which resets the
// internal sync sequence phase to 0 and reloads the free-running sysclk
// counter with clk_offset. If external sync was enabled when the request was
// captured, the block also drives ext_sync_o for EXT_SYNC_LEN cycles. That
// pulse starts in the same cycle as sync_o.
//
// The configuration inputs are quasi-static and come from another clock
// domain. They are sampled only when a request is accepted, so changing them
// mid-operation has no effect.
//
// Optional feature macro: TIO_SYNC_STATUS_EN
//   Defining it adds the sync_count_o and sync_err_o status ports.
//
// Ports
//   sys_clk_i        in   system clock (only clock)
//   sys_rst_n_i      in   synchronous active-low reset
//   sync_req_i       in   1-cycle sync request
//   sync_offset_i    in   [7:0] delay from request to sync, in sysclks
//   en_ext_sync_i    in   enable for the external sync pulse
//   clk_offset_i     in   [7:0] value loaded into the sysclk counter at sync
//   sync_o           out  1-cycle internal sync-sequence reset pulse
//   ext_sync_o       out  external sync pulse, EXT_SYNC_LEN cycles long
//   sysclk_count_o   out  [COUNT_WIDTH-1:0] free-running sysclk counter
//   seq_phase_o      out  [PHASE_W-1:0] sync sequence phase
//   sync_busy_o      out  high while a request is in progress
//   sync_count_o     out  [15:0] number of sync_o pulses (status build only)
//   sync_err_o       out  sticky: request seen while busy (status build only)
// ----------------------------------------------------------------------------
module tio_sync_ctrl #(
    parameter int COUNT_WIDTH  = 32,
    parameter int SEQ_LEN      = 8,
    parameter int EXT_SYNC_LEN = 4,
    localparam int PHASE_W     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic                   sys_clk_i,
    input  logic                   sys_rst_n_i,
    input  logic                   sync_req_i,
    input  logic [7:0]             sync_offset_i,
    input  logic                   en_ext_sync_i,
    input  logic [7:0]             clk_offset_i,
    output logic                   sync_o,
    output logic                   ext_sync_o,
    output logic [COUNT_WIDTH-1:0] sysclk_count_o,
    output logic [PHASE_W-1:0]     seq_phase_o,
    output logic                   sync_busy_o
`ifdef TIO_SYNC_STATUS_EN
    ,
    output logic [15:0]            sync_count_o,
    output logic                   sync_err_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FIRE,
        ST_EXT
    } state_t;

    state_t                 state_q,   state_d;
    logic [7:0]             dcnt_q,    dcnt_d;
    logic [7:0]             clk_off_q, clk_off_d;
    logic                   ext_en_q,  ext_en_d;
    logic                   sync_q,    sync_d;
    logic                   ext_q,     ext_d;
    logic [7:0]             ext_cnt_q, ext_cnt_d;
    logic [COUNT_WIDTH-1:0] count_q,   count_d;
    logic [PHASE_W-1:0]     phase_q,   phase_d;
    logic                   busy_q,    busy_d;

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        clk_off_d = clk_off_q;
        ext_en_d  = ext_en_q;
        sync_d    = 1'b0;
        ext_d     = ext_q;
        ext_cnt_d = ext_cnt_q;
        count_d   = count_q + COUNT_WIDTH'(1);
        phase_d   = (phase_q == PHASE_W'(SEQ_LEN - 1)) ? '0 : phase_q + PHASE_W'(1);

        case (state_q)
            ST_IDLE: begin
                // busy_q also covers the cycle in which sync_o or ext_sync_o is
                // still high after the FSM has already returned to IDLE.
                if (sync_req_i && !busy_q) begin
                    dcnt_d    = sync_offset_i;
                    clk_off_d = clk_offset_i;
                    ext_en_d  = en_ext_sync_i;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dcnt_q == 8'd0) begin
                    state_d = ST_FIRE;
                end else begin
                    dcnt_d = dcnt_q - 8'd1;
                end
            end
            ST_FIRE: begin
                // Counter reload, phase reset and the pulses all land on the
                // same edge, so they become visible together with sync_o.
                sync_d  = 1'b1;
                count_d = COUNT_WIDTH'(clk_off_q);
                phase_d = '0;
                if (ext_en_q) begin
                    ext_d     = 1'b1;
                    ext_cnt_d = 8'(EXT_SYNC_LEN - 1);
                    state_d   = ST_EXT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXT: begin
                if (ext_cnt_q == 8'd0) begin
                    ext_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    ext_cnt_d = ext_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ext_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE) || sync_d || ext_d;
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            state_q   <= ST_IDLE;
            dcnt_q    <= '0;
            clk_off_q <= '0;
            ext_en_q  <= 1'b0;
            sync_q    <= 1'b0;
            ext_q     <= 1'b0;
            ext_cnt_q <= '0;
            count_q   <= '0;
            phase_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            clk_off_q <= clk_off_d;
            ext_en_q  <= ext_en_d;
            sync_q    <= sync_d;
            ext_q     <= ext_d;
            ext_cnt_q <= ext_cnt_d;
            count_q   <= count_d;
            phase_q   <= phase_d;
            busy_q    <= busy_d;
        end
    end

    assign sync_o         = sync_q;
    assign ext_sync_o     = ext_q;
    assign sysclk_count_o = count_q;
    assign seq_phase_o    = phase_q;
    assign sync_busy_o    = busy_q;

`ifdef TIO_SYNC_STATUS_EN
    logic [15:0] sync_cnt_q, sync_cnt_d;
    logic        err_q,      err_d;

    always_comb begin
        // The count advances on the same edge that raises sync_o.
        sync_cnt_d = sync_d ? sync_cnt_q + 16'd1 : sync_cnt_q;
        err_d      = err_q | (sync_req_i & busy_q);
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            sync_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            sync_cnt_q <= sync_cnt_d;
            err_q      <= err_d;
        end
    end

    assign sync_count_o = sync_cnt_q;
    assign sync_err_o   = err_q;
`endif

endmodule

// File: tb/tb_tio_sync_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tio_sync_ctrl
//
// Scoreboard bench for tio_sync_ctrl, built with an 8-bit counter so that
// wrap-around can be reached. The stimulus pushes the expected sync events:
// cycle, counter value and whether the external pulse should fire. The monitor
// pops one event each time sync_o is high. In the remaining cycles it checks
// that the counter and phase step forward by one, that ext_sync_o is one
// EXT_LEN-cycle pulse, and that busy drops at the expected cycle.
// ----------------------------------------------------------------------------
module tb_tio_sync_ctrl;

    localparam int CW      = 8;
    localparam int SEQ     = 8;
    localparam int EXT_LEN = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic [7:0]    offset;
    logic          en_ext;
    logic [7:0]    clk_off;
    logic          sync_o;
    logic          ext_o;
    logic [CW-1:0] count_o;
    logic [2:0]    phase_o;
    logic          busy_o;
`ifdef TIO_SYNC_STATUS_EN
    logic [15:0]   sync_count_o;
    logic          sync_err_o;
`endif

    tio_sync_ctrl #(
        .COUNT_WIDTH  (CW),
        .SEQ_LEN      (SEQ),
        .EXT_SYNC_LEN (EXT_LEN)
    ) dut (
        .sys_clk_i      (clk),
        .sys_rst_n_i    (rst_n),
        .sync_req_i     (req),
        .sync_offset_i  (offset),
        .en_ext_sync_i  (en_ext),
        .clk_offset_i   (clk_off),
        .sync_o         (sync_o),
        .ext_sync_o     (ext_o),
        .sysclk_count_o (count_o),
        .seq_phase_o    (phase_o),
        .sync_busy_o    (busy_o)
`ifdef TIO_SYNC_STATUS_EN
        ,
        .sync_count_o   (sync_count_o),
        .sync_err_o     (sync_err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
        logic       ext;
    } exp_t;

    exp_t exp_q[$];
    int   busy_chk_q[$];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic rst_smp  = 1'b0;

    always @(posedge clk) begin
        cyc     = cyc + 1;
        rst_smp <= rst_n;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    int         prev_cnt = 0;
    int         prev_ph  = 0;
    logic       prev_ext = 1'b0;
    logic       prev_ok  = 1'b0;
    int         ext_run  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if (!rst_smp) begin
                chk("rst_sync", int'(sync_o), 0);
                chk("rst_ext", int'(ext_o), 0);
                chk("rst_busy", int'(busy_o), 0);
                chk("rst_count", int'(count_o), 0);
                chk("rst_phase", int'(phase_o), 0);
                ext_run = 0;
            end else begin
                if (sync_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_sync", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("sync event: cycle=%0d exp_cycle=%0d count=0x%0h phase=%0d ext=%0b busy=%0b",
                                 cyc, e.cyc, count_o, phase_o, ext_o, busy_o);
                        chk("sync_cycle", cyc, e.cyc);
                        chk("sync_count", int'(count_o), int'(e.cnt));
                        chk("sync_phase", int'(phase_o), 0);
                        chk("sync_ext", int'(ext_o), int'(e.ext));
                        chk("sync_busy", int'(busy_o), 1);
                        busy_chk_q.push_back(cyc + (e.ext ? EXT_LEN : 1));
                    end
                end else begin
                    if (prev_ok) begin
                        chk("count_step", int'(count_o), (prev_cnt + 1) % 256);
                        chk("phase_step", int'(phase_o), (prev_ph + 1) % SEQ);
                    end
                    if (ext_o && !prev_ext) chk("ext_without_sync", 1, 0);
                end
                if (ext_o) begin
                    ext_run++;
                end else if (prev_ext) begin
                    chk("ext_len", ext_run, EXT_LEN);
                    ext_run = 0;
                end
                if (busy_chk_q.size() > 0 && busy_chk_q[0] == cyc) begin
                    chk("busy_low", int'(busy_o), 0);
                    void'(busy_chk_q.pop_front());
                end
            end
            prev_ok  = 1'b1;
            prev_cnt = int'(count_o);
            prev_ph  = int'(phase_o);
            prev_ext = ext_o;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int n, input logic ext, input logic [7:0] co, input logic expect_accept);
        exp_t e;
        offset  = 8'(n);
        en_ext  = ext;
        clk_off = co;
        req     = 1'b1;
        if (expect_accept) begin
            e.cyc = cyc + n + 3;
            e.cnt = co;
            e.ext = ext;
            exp_q.push_back(e);
        end
        step();
        req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        busy_chk_q.delete();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        req     = 1'b0;
        offset  = 8'd0;
        en_ext  = 1'b0;
        clk_off = 8'd0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // offset 0, no ext; a request in the sync cycle itself is ignored
        issue(0, 1'b0, 8'h10, 1'b1);
        repeat (2) step();
        issue(7, 1'b1, 8'h55, 1'b0);
`ifdef TIO_SYNC_STATUS_EN
        chk("sync_err_set", int'(sync_err_o), 1);
        chk("sync_count", int'(sync_count_o), 1);
`endif
        repeat (5) step();

        // offset 5 with ext; offset changed after capture, extra requests ignored
        issue(5, 1'b1, 8'h20, 1'b1);
        offset = 8'd20;
        step();
        issue(3, 1'b0, 8'h99, 1'b0);
        repeat (8) step();
        issue(2, 1'b0, 8'h77, 1'b0);
        repeat (4) step();

        // reset during WAIT, then a fresh first-case request
        issue(10, 1'b1, 8'h33, 1'b0);
        repeat (3) step();
        do_reset();
        issue(0, 1'b0, 8'h10, 1'b1);
        repeat (6) step();

        // reset during EXT
        issue(1, 1'b1, 8'h44, 1'b1);
        repeat (4) step();
        chk("mid_ext_high", int'(ext_o), 1);
        do_reset();
        repeat (2) step();

        // counter wrap 0xFF -> 0x00 without sync
        n = 0;
        while (count_o != 8'hFF && n < 600) begin
            step();
            n++;
        end
        chk("wrap_reach_ff", int'(count_o), 8'hFF);
        step();
        chk("wrap_to_zero", int'(count_o), 0);

        // sync landing where phase would have been 5
        n = 0;
        while (phase_o != 3'd2 && n < 20) begin
            step();
            n++;
        end
        chk("phase_reach_2", int'(phase_o), 2);
        issue(0, 1'b0, 8'hAB, 1'b1);
        step();
        chk("phase_before_sync", int'(phase_o), 4);
        repeat (10) step();

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("busy_checks_empty", busy_chk_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
